// File: rtl/snn_fpga_pkg.sv
// Shared constants for the FPGA harness.
// Holds the spike-row geometry, the RAM address width, the number of rows per
// load and the state encoding of the input-pattern RAM loader.
package snn_fpga_pkg;

    // Spike-row width in bits (a whole number of bytes).
    localparam int M    = 256;
    // RAM address width.
    localparam int AW   = 16;
    // Rows per load: two 501-row images.
    localparam int ROWS = 1002;

    // Loader FSM encoding, kept as plain constants so older tools and
    // harness scripts can decode the raw state bits.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Number of byte lanes in a row of the given width.
    function automatic int bytesPerRow(input int width);
        return width / 8;
    endfunction

    // Width of a counter that indexes the byte lanes of a row.
    // A one-lane row still gets a 1-bit counter.
    function automatic int byteCountWidth(input int width);
        return (width / 8 > 1) ? $clog2(width / 8) : 1;
    endfunction

endpackage

// File: rtl/ip_ram_loader_if.sv
// Host-stream and RAM-write bundle of the input-pattern RAM loader.
// The master side is the host link plus the RAM and status consumers; the slave
// side is the loader itself.
interface ip_ram_loader_if #(
    parameter int M  = snn_fpga_pkg::M,
    parameter int AW = snn_fpga_pkg::AW
);

    logic          start;
    logic          abort;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic [AW-1:0] ram_addr;
    logic [M-1:0]  ram_wdata;
    logic          ram_we;
    logic          busy;
    logic          done;
    logic [7:0]    csum;

    modport master (
        output start, abort, byte_data, byte_valid,
        input  byte_ready, ram_addr, ram_wdata, ram_we, busy, done, csum
    );

    modport slave (
        input  start, abort, byte_data, byte_valid,
        output byte_ready, ram_addr, ram_wdata, ram_we, busy, done, csum
    );

endinterface

// File: rtl/ip_ram_loader_byte_row_packer.sv
// Packs a stream of bytes into one M-bit row, least significant byte first.
// The lane register is never cleared by clr: every lane is rewritten before
// the row is used again, so only the byte counter needs restarting.
module byte_row_packer
    import snn_fpga_pkg::bytesPerRow;
    import snn_fpga_pkg::byteCountWidth;
#(
    parameter int M = snn_fpga_pkg::M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load_en,
    input  logic [7:0]   byte_in,
    output logic         row_full,
    output logic [M-1:0] row_out
);

    localparam int            NB       = bytesPerRow(M);
    localparam int            CW       = byteCountWidth(M);
    localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);

    logic [CW-1:0] r_count;
    logic [M-1:0]  r_row;

    // The row is complete on the cycle its last lane is being loaded.
    assign row_full = load_en && (r_count == LAST_IDX);
    assign row_out  = r_row;

    // Byte-lane index: restarts on clr and wraps after the last lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load_en) begin
            r_count <= (r_count == LAST_IDX) ? '0 : r_count + 1'b1;
        end
    end

    // Lane register: the accepted byte lands in the lane selected by the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
        end else if (load_en) begin
            r_row[8*r_count +: 8] <= byte_in;
        end
    end

endmodule

// File: rtl/ip_ram_loader.sv
// Writer side of the input-pattern RAM.
// Takes a valid/ready byte stream from the host bridge, packs it into M-bit
// spike rows and writes one row per address from 0 up to ROWS-1. Also keeps a
// running XOR of every accepted byte so the host can confirm the transfer.
module ip_ram_loader
    import snn_fpga_pkg::ST_IDLE;
    import snn_fpga_pkg::ST_FILL;
    import snn_fpga_pkg::ST_WRITE;
    import snn_fpga_pkg::ST_DONE;
#(
    parameter int M    = snn_fpga_pkg::M,
    parameter int AW   = snn_fpga_pkg::AW,
    parameter int ROWS = snn_fpga_pkg::ROWS
) (
    input  logic            clk,
    input  logic            rst,
    ip_ram_loader_if.slave  bus
);

    // The final address is compared exactly, so the counter stops there
    // instead of wrapping.
    localparam logic [AW-1:0] LAST_ADDR = AW'(ROWS - 1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_csum;

    logic          w_inFill;
    logic          w_inWrite;
    logic          w_startOk;
    logic          w_abortOk;
    logic          w_accept;
    logic          w_rowFull;
    logic          w_packClr;
    logic [M-1:0]  w_row;

    assign w_inFill  = (r_state == ST_FILL);
    assign w_inWrite = (r_state == ST_WRITE);

    // Abort only has meaning during a load. It beats a byte transfer and a
    // start in the same cycle.
    assign w_abortOk = bus.abort && (w_inFill || w_inWrite);

    // A start is honoured only from IDLE or DONE. A start during a load is
    // dropped.
    assign w_startOk = bus.start && !bus.abort &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // byte_ready is a pure decode of the state register, so a byte moves
    // whenever FILL meets byte_valid, unless an abort is cancelling the load.
    assign w_accept  = w_inFill && bus.byte_valid && !bus.abort;

    // Restart the lane counter for a new load, after each row write, and when
    // an abort throws away a partial row.
    assign w_packClr = w_startOk || w_inWrite || w_abortOk;

    byte_row_packer #(
        .M (M)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_packClr),
        .load_en  (w_accept),
        .byte_in  (bus.byte_data),
        .row_full (w_rowFull),
        .row_out  (w_row)
    );

    // Load sequencing: fill a row, write it for one cycle, then advance the
    // address or finish. Aborts drop back to IDLE and keep address and
    // checksum visible for debug.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_csum  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_startOk) begin
                        r_state <= ST_FILL;
                        r_addr  <= '0;
                        r_csum  <= '0;
                    end
                end
                ST_FILL: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        r_csum <= r_csum ^ bus.byte_data;
                        if (w_rowFull) begin
                            r_state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                    end else if (r_addr == LAST_ADDR) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= ST_FILL;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and RAM outputs are decodes of the registered state. The write
    // strobe is also masked by abort so that an aborted WRITE never reaches
    // the RAM.
    assign bus.byte_ready = w_inFill;
    assign bus.ram_we     = w_inWrite && !bus.abort;
    assign bus.busy       = w_inFill || w_inWrite;
    assign bus.done       = (r_state == ST_DONE);
    assign bus.ram_addr   = r_addr;
    assign bus.ram_wdata  = w_row;
    assign bus.csum       = r_csum;

endmodule

// File: tb/tb_ip_ram_loader.sv
// Self-checking bench for ip_ram_loader.
// A reference model turns the accepted byte stream into expected row writes.
// A monitor pops and compares each row whenever the loader strobes ram_we.
module tb_ip_ram_loader;
    import snn_fpga_pkg::*;

    localparam int NB = M / 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [M-1:0]  data;
    } write_t;

    logic clk;
    logic rst;

    int testsRun  = 0;
    int failCount = 0;

    // Reference model state.
    logic [7:0] pendBytes[$];
    write_t     expQ[$];
    int         modelRow;
    logic [7:0] modelCsum;
    int         writesSeen = 0;

    // Observations from the one-row instance.
    int          smallWeCount = 0;
    logic [AW-1:0] smallAddr;
    logic [M-1:0]  smallData;

    ip_ram_loader_if #(.M(M), .AW(AW)) bus ();
    ip_ram_loader_if #(.M(M), .AW(AW)) busSmall ();

    ip_ram_loader #(.M(M), .AW(AW), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ip_ram_loader #(.M(M), .AW(AW), .ROWS(1)) dutSmall (
        .clk (clk),
        .rst (rst),
        .bus (busSmall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record a check that failed outright, such as a timeout.
    task automatic failNow(input string name);
        testsRun++;
        failCount++;
        $display("[TB] FAIL %s: got timeout/unexpected event expected normal progress", name);
    endtask

    // Inputs change 1 time unit after the falling edge, away from both edges.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic modelStart();
        pendBytes.delete();
        modelRow  = 0;
        modelCsum = 8'h00;
    endtask

    task automatic modelAbort();
        pendBytes.delete();
    endtask

    // The loader accepted byte d. After a full row, queue the row write the
    // loader must then produce at the next address.
    task automatic modelAccept(input logic [7:0] d);
        logic [M-1:0] row;
        write_t       w;
        pendBytes.push_back(d);
        modelCsum = modelCsum ^ d;
        if (pendBytes.size() == NB) begin
            row = '0;
            for (int k = 0; k < NB; k++) row[8*k +: 8] = pendBytes[k];
            w.addr = modelRow[AW-1:0];
            w.data = row;
            expQ.push_back(w);
            modelRow++;
            pendBytes.delete();
        end
    endtask

    // Offer one byte on the main loader, hold it until accepted, and report
    // how many cycles it stalled.
    task automatic applyStimulus(input logic [7:0] d, output int waited);
        waited = 0;
        bus.byte_data  = d;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        if (waited >= 100) begin
            failNow("byte_ready_timeout");
            bus.byte_valid = 1'b0;
        end else begin
            @(posedge clk);
            modelAccept(d);
            tick();
        end
    endtask

    task automatic idleCycles(input int n);
        bus.byte_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Row-write monitor for the main loader.
    always @(negedge clk) begin : monMain
        write_t w;
        if (bus.ram_we === 1'b1) begin
            writesSeen++;
            checkOutput("ready_low_in_write", M'(bus.byte_ready), M'(0));
            if (expQ.size() == 0) begin
                failNow("unexpected_write");
            end else begin
                w = expQ.pop_front();
                checkOutput("write_addr", M'(bus.ram_addr), M'(w.addr));
                checkOutput("write_data", bus.ram_wdata, w.data);
            end
        end
    end

    // Row-write capture for the one-row loader.
    always @(negedge clk) begin : monSmall
        if (busSmall.ram_we === 1'b1) begin
            smallWeCount++;
            smallAddr = busSmall.ram_addr;
            smallData = busSmall.ram_wdata;
        end
    end

    // Watchdog so a stuck loader still ends the run.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        int           waited;
        int           writesAtStart;
        int           budget;
        logic [M-1:0] expRow;
        logic [7:0]   b;

        bus.start = 0; bus.abort = 0; bus.byte_data = 0; bus.byte_valid = 0;
        busSmall.start = 0; busSmall.abort = 0; busSmall.byte_data = 0; busSmall.byte_valid = 0;
        modelStart();
        rst = 1'b1;
        repeat (3) tick();

        // Reset state.
        checkOutput("rst_byte_ready", M'(bus.byte_ready), M'(0));
        checkOutput("rst_ram_we", M'(bus.ram_we), M'(0));
        checkOutput("rst_busy", M'(bus.busy), M'(0));
        checkOutput("rst_done", M'(bus.done), M'(0));
        checkOutput("rst_ram_addr", M'(bus.ram_addr), M'(0));
        checkOutput("rst_ram_wdata", bus.ram_wdata, M'(0));
        checkOutput("rst_csum", M'(bus.csum), M'(0));
        rst = 1'b0;
        tick();

        // One-row load of bytes 0x00..0x1F on the ROWS=1 instance.
        busSmall.start = 1'b1;
        tick();
        busSmall.start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            waited = 0;
            busSmall.byte_data  = 8'(i);
            busSmall.byte_valid = 1'b1;
            while (busSmall.byte_ready !== 1'b1 && waited < 20) begin
                tick();
                waited++;
            end
            if (waited >= 20) failNow("small_ready_timeout");
            @(posedge clk);
            tick();
        end
        busSmall.byte_valid = 1'b0;
        repeat (3) tick();
        expRow = '0;
        for (int k = 0; k < NB; k++) expRow[8*k +: 8] = 8'(k);
        checkOutput("small_we_count", M'(smallWeCount), M'(1));
        checkOutput("small_addr", M'(smallAddr), M'(0));
        checkOutput("small_low_byte", M'(smallData[7:0]), M'(8'h00));
        checkOutput("small_high_byte", M'(smallData[M-1:M-8]), M'(8'h1F));
        checkOutput("small_row", smallData, expRow);
        checkOutput("small_done", M'(busSmall.done), M'(1));
        checkOutput("small_busy", M'(busSmall.busy), M'(0));
        checkOutput("small_csum", M'(busSmall.csum), M'(8'h00));
        checkOutput("small_refuse_in_done", M'(busSmall.byte_ready), M'(0));

        // Asynchronous reset in the middle of a row.
        pulseStart();
        modelStart();
        for (int i = 0; i < 5; i++) applyStimulus(8'(1 << i), waited);
        checkOutput("pre_rst_csum", M'(bus.csum), M'(8'h1F));
        checkOutput("pre_rst_busy", M'(bus.busy), M'(1));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_byte_ready", M'(bus.byte_ready), M'(0));
        checkOutput("midrst_busy", M'(bus.busy), M'(0));
        checkOutput("midrst_done", M'(bus.done), M'(0));
        checkOutput("midrst_ram_addr", M'(bus.ram_addr), M'(0));
        checkOutput("midrst_csum", M'(bus.csum), M'(0));
        tick();
        checkOutput("midrst_ram_we", M'(bus.ram_we), M'(0));
        rst = 1'b0;
        bus.byte_valid = 1'b0;
        modelStart();
        tick();

        // Abort after 10 bytes of row 3. The byte offered in the abort cycle
        // must be refused.
        pulseStart();
        modelStart();
        for (int i = 0; i < 3 * NB + 10; i++) applyStimulus(8'($urandom_range(0, 255)), waited);
        bus.abort      = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        tick();
        bus.abort      = 1'b0;
        bus.byte_valid = 1'b0;
        modelAbort();
        checkOutput("abort_busy", M'(bus.busy), M'(0));
        checkOutput("abort_done", M'(bus.done), M'(0));
        checkOutput("abort_byte_ready", M'(bus.byte_ready), M'(0));
        checkOutput("abort_ram_addr", M'(bus.ram_addr), M'(3));
        checkOutput("abort_csum", M'(bus.csum), M'(modelCsum));
        repeat (5) tick();
        checkOutput("abort_writes", M'(writesSeen), M'(3));
        checkOutput("abort_queue_drained", M'(expQ.size()), M'(0));

        // Full load with random gaps. A new start goes back to address 0, and
        // a start during row 5 is ignored.
        writesAtStart = writesSeen;
        pulseStart();
        modelStart();
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < NB; k++) begin
                if (r == 5 && k == 4) begin
                    idleCycles(1);
                    pulseStart();
                end
                if (k != 0 && $urandom_range(0, 4) == 0) idleCycles($urandom_range(1, 2));
                b = 8'($urandom_range(0, 255));
                applyStimulus(b, waited);
                if (r > 0 && k == 0) checkOutput("held_byte_stall", M'(waited), M'(1));
            end
        end
        idleCycles(1);
        budget = 0;
        while (bus.done !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        if (budget >= 20) failNow("done_timeout");
        checkOutput("load_done", M'(bus.done), M'(1));
        checkOutput("load_busy", M'(bus.busy), M'(0));
        checkOutput("load_last_addr", M'(bus.ram_addr), M'(ROWS - 1));
        checkOutput("load_csum", M'(bus.csum), M'(modelCsum));
        checkOutput("load_write_count", M'(writesSeen - writesAtStart), M'(ROWS));
        checkOutput("load_queue_drained", M'(expQ.size()), M'(0));
        checkOutput("load_refuse_in_done", M'(bus.byte_ready), M'(0));

        // Start in DONE: the next cycle shows done cleared and a fresh load.
        pulseStart();
        modelStart();
        checkOutput("restart_done", M'(bus.done), M'(0));
        checkOutput("restart_busy", M'(bus.busy), M'(1));
        checkOutput("restart_byte_ready", M'(bus.byte_ready), M'(1));
        checkOutput("restart_ram_addr", M'(bus.ram_addr), M'(0));
        checkOutput("restart_csum", M'(bus.csum), M'(0));

        // Abort and start in the same FILL cycle: the abort wins.
        for (int i = 0; i < 7; i++) applyStimulus(8'($urandom_range(0, 255)), waited);
        bus.abort      = 1'b1;
        bus.start      = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h55;
        tick();
        bus.abort      = 1'b0;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        modelAbort();
        checkOutput("abort_start_busy", M'(bus.busy), M'(0));
        checkOutput("abort_start_done", M'(bus.done), M'(0));
        checkOutput("abort_start_byte_ready", M'(bus.byte_ready), M'(0));
        checkOutput("abort_start_csum", M'(bus.csum), M'(modelCsum));
        repeat (5) tick();
        checkOutput("final_queue_drained", M'(expQ.size()), M'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
